// File: rtl/dbus_bridge_pkg.sv
// Shared constants for the data-bus bridge: FSM encoding, logic levels and the
// default read data returned when an access times out.
package dbus_bridge_pkg;

   localparam logic        ON   = 1'b1;
   localparam logic        OFF  = 1'b0;
   localparam logic [31:0] ZERO = 32'h0000_0000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [31:0] ERR_RDATA_DEF = 32'h0000_0000;

endpackage

// File: rtl/dbus_bridge.sv
// Bridges the single-cycle CPU data port to a req/ack slave, stalling the CPU until
// each access completes; a per-access timeout forces completion and sets a sticky error.
module dbus_bridge
   import dbus_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEF
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iReadEnable,
   input  logic        iWriteEnable,
   input  logic [3:0]  iByteEnable,
   input  logic [31:0] iAddress,
   input  logic [31:0] iWriteData,
   output logic [31:0] oReadData,
   output logic        oStall,
   output logic        oMemReq,
   output logic        oMemWe,
   output logic [3:0]  oMemBe,
   output logic [31:0] oMemAddr,
   output logic [31:0] oMemWData,
   input  logic        iMemAck,
   input  logic [31:0] iMemRData,
   output logic        oBusError
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

   logic [1:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [3:0]      be_q, be_d;
   logic [31:0]     addr_q, addr_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            access;
   logic            unused_addr_lsb;

   assign access          = iReadEnable | iWriteEnable;
   assign cnt_inc         = cnt_q + CntW'(1);
   assign unused_addr_lsb = ^iAddress[1:0];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               we_d    = iWriteEnable;
               be_d    = iByteEnable;
               addr_d  = {iAddress[31:2], 2'b00};
               wdata_d = iWriteData;
               cnt_d   = '0;
               req_d   = ON;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // cnt_inc is the 1-based index of the current WAIT cycle
            cnt_d = cnt_inc;
            if (iMemAck) begin
               if (!we_q) rdata_d = iMemRData;
               req_d   = OFF;
               state_d = ST_DONE;
            end else if (cnt_inc == TimeoutCnt) begin
               rdata_d = ERR_RDATA;
               err_d   = ON;
               req_d   = OFF;
               state_d = ST_DONE;
            end
         end
         // The request still on the inputs here is the one just completed
         ST_DONE: state_d = ST_IDLE;
         default: begin
            req_d   = OFF;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= OFF;
         we_q    <= OFF;
         be_q    <= 4'b0000;
         addr_q  <= ZERO;
         wdata_q <= ZERO;
         rdata_q <= ZERO;
         err_q   <= OFF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign oStall    = ((state_q == ST_IDLE) & access) | (state_q == ST_WAIT);
   assign oReadData = rdata_q;
   assign oMemReq   = req_q;
   assign oMemWe    = we_q;
   assign oMemBe    = be_q;
   assign oMemAddr  = addr_q;
   assign oMemWData = wdata_q;
   assign oBusError = err_q;

endmodule

// File: doc/dbus_bridge.md
# dbus_bridge

Data-bus bridge between the uniciclo datapath's Dw* data port and a variable-latency memory/MMIO slave using a req/ack handshake. It latches each load or store, runs the handshake, and raises a combinational stall so the CPU holds PC until the access completes. A cycle-counted timeout guarantees forward progress and flags a sticky bus error.

## Interface
- TIMEOUT, 255: max cycles in WAIT before abort (1..65535)
- ERR_RDATA, 32'h0000_0000: read data returned on timeout
- iCLK  in  1  clock; reset iRST, asynchronous, active-high
- iRST  in  1  reset
- iReadEnable  in  1  CPU load request (DwReadEnable)
- iWriteEnable  in  1  CPU store request (DwWriteEnable)
- iByteEnable  in  4  byte lanes (DwByteEnable)
- iAddress  in  32  byte address (DwAddress)
- iWriteData  in  32  store data (DwWriteData)
- oReadData  out  32  load data to MemLoad (DwReadData)
- oStall  out  1  hold PC and register-file write
- oMemReq  out  1  slave request, level held until ack
- oMemWe  out  1  1 = write
- oMemBe  out  4  latched byte enables
- oMemAddr  out  32  latched address, bits [1:0] forced 0
- oMemWData  out  32  latched write data
- iMemAck  in  1  slave completion, 1-cycle pulse
- iMemRData  in  32  read data, valid with iMemAck
- oBusError  out  1  sticky: a timeout occurred since reset

## Operation
- FSM states IDLE, WAIT, DONE.
- IDLE: if iReadEnable|iWriteEnable, latch address/BE/data/we (we = iWriteEnable; write wins if both), go WAIT. Else stay.
- WAIT: oMemReq=1. On iMemAck: if read, capture iMemRData into read register; go DONE. Counter increments each WAIT cycle; on count == TIMEOUT without ack: read register <= ERR_RDATA, oBusError <= 1, go DONE.
- DONE: oMemReq=0; always go IDLE next cycle (the request still visible on inputs this cycle is the completed one and must not be re-issued).
- oStall = (IDLE & (iReadEnable|iWriteEnable)) | WAIT. Deasserted in DONE, so the CPU commits exactly once per access.
- oReadData = read register; holds last captured value until the next read completes. Stores do not modify it.
- Ack in IDLE or DONE is ignored (spurious); no state change.
- Counter clears on entry to WAIT; width clog2(TIMEOUT+1).

## Timing
- Reset values: state IDLE, oMemReq 0, oMemWe 0, oMemBe 0, oMemAddr 0, oMemWData 0, read register 0, counter 0, oBusError 0; oStall follows inputs combinationally.
- Minimum access: request cycle (IDLE, stall) -> WAIT with ack same cycle -> DONE: 3 cycles, 2 stalled.
- Ack on k-th WAIT cycle (k>=1): total stall = k+1 cycles.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then DONE; stall = TIMEOUT+1.
- Ack on the same cycle as count == TIMEOUT: ack wins, no error.
- oMemReq/oMem* are registered; stable throughout WAIT.
- iRST mid-access: immediate return to IDLE, oMemReq drops asynchronously; slave must discard the outstanding transaction.

## Structure
- State encoding (IDLE/WAIT/DONE) and ERR_RDATA default go in the shared Parametros package alongside ON/OFF/ZERO.
- Single module; the timeout counter is inline. No sub-module needed.

## Test plan
- Load, ack on 1st WAIT cycle, iMemRData=32'h1234_5678 -> oStall high 2 cycles, oReadData=32'h1234_5678 in DONE, oMemReq low in DONE.
- Store addr 32'h1001_0003, BE 4'b1000, data 32'hAB00_0000, ack after 3 cycles -> oMemAddr=32'h1001_0000, oMemWe=1, oMemBe=4'b1000, stall 4 cycles, oReadData unchanged.
- TIMEOUT=4, no ack -> WAIT exactly 4 cycles, oReadData=ERR_RDATA, oBusError=1 and remains 1 through later good accesses.
- Ack coincident with count==TIMEOUT, iMemRData=32'h0000_00FF -> oReadData=32'h0000_00FF, oBusError stays 0.
- Back-to-back loads (request held across DONE then new address) -> exactly two slave transactions, no duplicate issue in DONE.
- iRST pulsed during WAIT -> oMemReq 0 immediately, state IDLE, oReadData 0, oBusError 0.
